param_window_detector: RTL and testbench
========================================

Name: param_window_detector

Overview:
Next-generation sliding-window sequence detector for the serial-input lab datapath. It shifts a qualified serial bit stream into a W-bit window and compares the window against a runtime-loadable pattern under a per-bit care mask. It selects overlapping or non-overlapping detection, and it keeps a saturating match counter. It sits between the serial input source and the LED/7-segment display logic. It replaces the fixed-pattern, fixed-length detector.

Parameters:
W, 7, window/pattern length in bits (2..32)
PATTERN, 7'b1110011, reset pattern; MSB = oldest bit in window
CNT_W, 8, match counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in  in  1  serial data bit
in_valid  in  1  qualifies in; window shifts only when high
pat_load  in  1  load pat_in/mask_in and restart detection
pat_in  in  W  new pattern, MSB = oldest bit
mask_in  in  W  care mask; 1 = bit compared, 0 = don't care
overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
cnt_clr  in  1  clear match counter
dec  out  1  one-cycle match pulse, registered
match_cnt  out  CNT_W  saturating count of matches
armed  out  1  high when window holds W fresh bits (state ARMED)

Behaviour:
- Reset (rst high at clk edge): sr=0, pattern=PATTERN, mask=all ones, fill=0, state=FILL, dec=0, match_cnt=0, armed=0.
- Shift: on an edge with in_valid=1 and pat_load=0, sr <= {sr[W-2:0], in}. sr[W-1] is the oldest bit. fill increments and saturates at W. fill width is $clog2(W+1).
- Match condition: evaluated on the next-window value nsr. hit = state ARMED-after-shift (fill reaches W on this edge or is already W) && ((nsr ^ pattern) & mask) == 0 && mask != 0.
- mask == 0 means the detector is disabled; it never matches.
- dec: registered. It is high for exactly one cycle after the edge on which hit is true, so latency from the completing bit's edge is 1 cycle. Otherwise dec=0, including on cycles with in_valid=0.
- FSM states:
  - FILL: fewer than W bits since restart. Go to ARMED when fill reaches W.
  - ARMED: compare on every valid bit. On hit: if overlap=1, stay in ARMED. If overlap=0, go to HOLDOFF with fill=0.
  - HOLDOFF: same as FILL, but entered only after a match. Go to ARMED after W new valid bits.
- armed = (state == ARMED).
- overlap is sampled on each hit edge. Changing it mid-stream affects only later hits.
- pat_load: has priority over in_valid. On that edge: pattern <= pat_in, mask <= mask_in, fill=0, state=FILL, sr unchanged, dec=0 on the next cycle. A simultaneous in bit is discarded.
- match_cnt: increments on each hit and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr without hit: match_cnt=0. cnt_clr with hit on the same edge: match_cnt=1.
- rst has priority over all other inputs. A reset mid-sequence discards a partial match. No dec for any bits shifted before reset.

Decomposition:
- Shared header swsd_defs.vh holds:
  - state encodings: FILL=2'd0, ARMED=2'd1, HOLDOFF=2'd2; 2'd3 is illegal and recovers to FILL.
  - default PATTERN constant.
- One natural sub-module: sat_counter (parameter CNT_W; inputs inc and clr; output count), instantiated for match_cnt.
- Shift register, comparator and FSM stay in the top module.

Test Plan:
- Defaults (W=7, PATTERN=1110011, mask all ones, overlap=1): after rst, feed 1,1,1,0,0,1,1 with in_valid=1 -> dec=1 one cycle after the 7th bit edge; match_cnt=1; no dec on bits 1-6.
- Overlap: load pat=1010101, mask all ones. Feed 1,0,1,0,1,0,1,0,1 -> overlap=1 gives dec after bits 7 and 9, match_cnt=2. Repeat with overlap=0 -> dec only after bit 7, match_cnt=1, armed=0 for the next 7 bits.
- Mask/disable: load pat=1110000, mask=1110000. Feed 1,1,1,0,1,0,1 -> dec after bit 7. Load mask=0 and feed the same bits -> no dec, match_cnt unchanged.
- Gating and load priority: hold in_valid=0 mid-pattern for 3 cycles -> sr unchanged and match still detected on completion. Assert pat_load with in_valid=1 at bit 4 -> bit dropped, armed=0, fill restarts.
- Reset mid-operation: feed 1,1,1,0,0, assert rst 1 cycle, feed 1,1 -> no dec, match_cnt=0. Then feed the full 7-bit pattern -> dec once.
- Counter: CNT_W=2, produce 5 matches -> match_cnt 1,2,3,3,3. cnt_clr alone -> 0. cnt_clr on a hit edge -> 1.

Source files
------------

// File: rtl/param_window_detector_pkg.sv
// rtl/param_window_detector_pkg.sv - shared state encodings and default pattern for the window detector
// Contents: state_t (FILL/ARMED/HOLDOFF; encoding 2'd3 is illegal and
// recovers to FILL), DEFAULT_PATTERN (MSB = oldest bit in window).
package param_window_detector_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [6:0] DEFAULT_PATTERN = 7'b1110011;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear
// Ports: clk, rst (sync active-high), inc (count one event), clr (restart
// from zero; an inc on the same edge is still counted), count (holds at max).
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/param_window_detector.sv
// rtl/param_window_detector.sv - sliding-window masked pattern detector with saturating match count
// Ports: clk, rst (sync active-high), in/in_valid (serial bit + qualifier),
// pat_load/pat_in/mask_in (load pattern and care mask, restart detection),
// overlap (1 = overlapping matches), cnt_clr (clear counter),
// dec (registered one-cycle match pulse), match_cnt (saturating count),
// armed (window holds W fresh bits).
module param_window_detector
    import param_window_detector_pkg::*;
#(
    parameter int             W       = 7,
    parameter logic [W-1:0]   PATTERN = DEFAULT_PATTERN,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [W-1:0]     pat_in,
    input  logic [W-1:0]     mask_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             dec,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int             FW        = $clog2(W + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(W);

    logic [W-1:0]  sr;
    logic [W-1:0]  nsr;
    logic [W-1:0]  pattern;
    logic [W-1:0]  mask;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_inc;
    logic [FW-1:0] fill_next;
    state_t        state;
    state_t        state_next;
    logic          shift;
    logic          hit;

    // pat_load wins over a simultaneous valid bit, which is dropped.
    assign shift    = in_valid && !pat_load;
    assign nsr      = {sr[W-2:0], in};
    assign fill_inc = (fill == FILL_FULL) ? fill : fill + FW'(1);

    // Compare against the window as it will be after this shift; the window
    // must hold W fresh bits once the shift lands. An all-zero mask disables.
    assign hit = shift && (fill_inc == FILL_FULL) && (mask != '0) &&
                 (((nsr ^ pattern) & mask) == '0);

    always_comb begin
        state_next = state;
        fill_next  = fill;
        if (pat_load) begin
            state_next = ST_FILL;
            fill_next  = '0;
        end else begin
            case (state)
                ST_FILL, ST_HOLDOFF: begin
                    if (shift) begin
                        fill_next = fill_inc;
                        if (fill_inc == FILL_FULL) begin
                            state_next = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (shift) begin
                        fill_next = fill_inc;
                    end
                end
                default: begin
                    state_next = ST_FILL;
                    fill_next  = '0;
                end
            endcase
            // Non-overlapping mode: the matched bits cannot seed the next match.
            if (hit && !overlap) begin
                state_next = ST_HOLDOFF;
                fill_next  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            pattern <= PATTERN;
            mask    <= '1;
            fill    <= '0;
            state   <= ST_FILL;
            dec     <= 1'b0;
        end else begin
            dec   <= hit;
            state <= state_next;
            fill  <= fill_next;
            if (pat_load) begin
                pattern <= pat_in;
                mask    <= mask_in;
            end
            if (shift) begin
                sr <= nsr;
            end
        end
    end

    assign armed = (state == ST_ARMED);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit),
        .clr  (cnt_clr),
        .count(match_cnt)
    );

endmodule

// File: tb/tb_param_window_detector.sv
// tb/tb_param_window_detector.sv - directed self-checking bench for param_window_detector
module tb_param_window_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [6:0] pat_in = '0;
    logic [6:0] mask_in = '0;
    logic       overlap = 1'b1;
    logic       cnt_clr = 1'b0;

    logic       dec, armed, dec2, armed2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_window_detector #(.W(7), .PATTERN(7'b1110011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid),
        .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
        .overlap(overlap), .cnt_clr(cnt_clr),
        .dec(dec), .match_cnt(match_cnt), .armed(armed)
    );

    param_window_detector #(.W(7), .PATTERN(7'b1110011), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid),
        .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
        .overlap(overlap), .cnt_clr(cnt_clr),
        .dec(dec2), .match_cnt(match_cnt2), .armed(armed2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic feed(input logic b, input logic exp_dec, input string tag);
        in_bit   = b;
        in_valid = 1'b1;
        tick();
        chk(tag, dec, exp_dec);
    endtask

    task automatic feed_seq(input logic [15:0] bits, input int n, input logic [15:0] dmask, input string tag);
        for (int i = 0; i < n; i++) begin
            feed(bits[n-1-i], dmask[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
        end
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        tick();
        chk(tag, dec, 1'b0);
    endtask

    task automatic load(input logic [6:0] p, input logic [6:0] m, input logic clr, input string tag);
        pat_in   = p;
        mask_in  = m;
        pat_load = 1'b1;
        cnt_clr  = clr;
        tick();
        chk({tag, "_armed"}, armed, 1'b0);
        chk({tag, "_dec"}, dec, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dec", dec, 1'b0);
        chk("rst_cnt", match_cnt, 8'd0);
        chk("rst_armed", armed, 1'b0);

        // Default pattern, overlap on
        feed_seq(16'b1110011, 7, 16'b0000001, "t1");
        chk("t1_armed", armed, 1'b1);
        chk("t1_cnt", match_cnt, 8'd1);
        idle("t1_idle");

        // Overlapping 1010101
        overlap = 1'b1;
        load(7'b1010101, 7'h7f, 1'b1, "t2_load");
        chk("t2_cnt0", match_cnt, 8'd0);
        feed_seq(16'b101010101, 9, 16'b000000101, "t2o");
        chk("t2o_cnt", match_cnt, 8'd2);

        // Non-overlapping: holdoff for 7 fresh bits after the hit
        overlap = 1'b0;
        load(7'b1010101, 7'h7f, 1'b1, "t2n_load");
        feed_seq(16'b101010101, 9, 16'b000000100, "t2n");
        chk("t2n_cnt", match_cnt, 8'd1);
        chk("t2n_armed9", armed, 1'b0);
        feed_seq(16'b0101, 4, 16'b0, "t2n_h");
        chk("t2n_armed13", armed, 1'b0);
        feed(1'b0, 1'b0, "t2n_b14");
        chk("t2n_armed14", armed, 1'b1);

        // Masked compare, then disabled by zero mask
        overlap = 1'b1;
        load(7'b1110000, 7'b1110000, 1'b1, "t3_load");
        feed_seq(16'b1110101, 7, 16'b0000001, "t3m");
        chk("t3m_cnt", match_cnt, 8'd1);
        load(7'b1110000, 7'b0000000, 1'b0, "t3z_load");
        feed_seq(16'b1110101, 7, 16'b0, "t3z");
        chk("t3z_cnt", match_cnt, 8'd1);

        // in_valid gaps mid-pattern
        load(7'b1110011, 7'h7f, 1'b1, "t4_load");
        feed_seq(16'b111, 3, 16'b0, "t4a");
        in_bit = 1'b0;
        idle("t4_gap1");
        in_bit = 1'b1;
        idle("t4_gap2");
        in_bit = 1'b0;
        idle("t4_gap3");
        feed_seq(16'b0011, 4, 16'b0001, "t4b");
        chk("t4_cnt", match_cnt, 8'd1);
        chk("t4_armed", armed, 1'b1);

        // pat_load with a valid bit: bit dropped, fill restarts
        feed_seq(16'b111, 3, 16'b0, "t4c");
        chk("t4c_armed", armed, 1'b1);
        in_bit   = 1'b0;
        in_valid = 1'b1;
        load(7'b1110011, 7'h7f, 1'b0, "t4_ldv");
        feed_seq(16'b1110011, 7, 16'b0000001, "t4d");
        chk("t4d_cnt", match_cnt, 8'd2);

        // Reset mid-sequence
        feed_seq(16'b11100, 5, 16'b0, "t5a");
        rst = 1'b1;
        tick();
        chk("t5_rst_dec", dec, 1'b0);
        chk("t5_rst_cnt", match_cnt, 8'd0);
        chk("t5_rst_armed", armed, 1'b0);
        feed_seq(16'b11, 2, 16'b0, "t5b");
        chk("t5b_cnt", match_cnt, 8'd0);
        feed_seq(16'b1110011, 7, 16'b0000001, "t5c");
        chk("t5c_cnt", match_cnt, 8'd1);

        // Saturation on the 2-bit counter
        cnt_clr = 1'b1;
        idle("t6_clr");
        chk("t6_cnt2_0", match_cnt2, 2'd0);
        for (int k = 0; k < 5; k++) begin
            feed_seq(16'b1110011, 7, 16'b0000001, $sformatf("t6_m%0d", k + 1));
            chk($sformatf("t6_cnt2_%0d", k + 1), match_cnt2, (k < 3) ? k + 1 : 3);
        end
        chk("t6_cnt_main", match_cnt, 8'd5);
        cnt_clr = 1'b1;
        idle("t6_clr2");
        chk("t6_cnt2_clr", match_cnt2, 2'd0);
        feed_seq(16'b111001, 6, 16'b0, "t6h");
        cnt_clr = 1'b1;
        feed(1'b1, 1'b1, "t6h_b7");
        chk("t6_cnt2_clrhit", match_cnt2, 2'd1);
        chk("t6_cnt_clrhit", match_cnt, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
